// File: rtl/adder.sv
// Registered ripple-carry bit-slice ALU datapath.
// Each slice does AND, OR, pass-B or full-add on A, selected B and carry-in.
module mux_2x1 (
  input  logic [1:0] in,
  input  logic       sel,
  output logic       out
);
  assign out = in[sel];
endmodule

module adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_invert,
  input  logic             Cin,
  input  logic             Cout_sel,
  input  logic [1:0]       sum_sel,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             overflow
);
  logic [WIDTH-1:0] bi;
  logic [WIDTH-1:0] ci;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] s;

  // Slice i takes its carry-in from slice i-1; slice 0 takes Cin.
  assign ci = {c[WIDTH-2:0], Cin};

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    mux_2x1 u_bmux (
      .in  ({~B[i], B[i]}),
      .sel (b_invert),
      .out (bi[i])
    );

    assign c[i] = Cout_sel &
                  ((A[i] & bi[i]) |
                   (A[i] & ci[i]) |
                   (bi[i] & ci[i]));
  end

  always_comb begin
    s = '0;
    unique case (sum_sel)
      2'b00: s = A & bi;
      2'b01: s = A | bi;
      2'b10: s = bi;
      2'b11: s = A ^ bi ^ ci;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum      <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= s;
      Cout     <= c[WIDTH-1];
      overflow <= c[WIDTH-1] ^ c[WIDTH-2];
    end
  end
endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for the adder datapath.
// One task per scenario; expected values computed by hand.
module tb_adder;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         b_invert = 1'b0;
  logic         Cin = 1'b0;
  logic         Cout_sel = 1'b0;
  logic [1:0]   sum_sel = 2'b00;
  logic [W-1:0] sum;
  logic         Cout;
  logic         overflow;

  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LA = 64'd759231314;
  localparam logic [W-1:0] LB = 64'd371914018;

  adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .b_invert (b_invert),
    .Cin      (Cin),
    .Cout_sel (Cout_sel),
    .sum_sel  (sum_sel),
    .sum      (sum),
    .Cout     (Cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic binv, input logic cin,
                       input logic csel, input logic [1:0] ssel);
    A = a;
    B = b;
    b_invert = binv;
    Cin = cin;
    Cout_sel = csel;
    sum_sel = ssel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(ONES, ONES, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_c1 got %h/%b/%b want 0/0/0", sum, Cout, overflow);
    end
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_c2 got %h/%b/%b want 0/0/0", sum, Cout, overflow);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {ONES << 1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release got %h/%b/%b want fff..fe/1/0",
               sum, Cout, overflow);
    end
  endtask

  task automatic test_add();
    drive(64'd10000, 64'd10000, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd20000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_pos got %h/%b/%b want %h/0/0",
               sum, Cout, overflow, 64'd20000);
    end
    drive(-64'd53024, -64'd42502, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {-64'd95526, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_neg got %h/%b/%b want %h/1/0",
               sum, Cout, overflow, -64'd95526);
    end
    drive(64'd2, ONES, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_mixed got %h/%b/%b want 1/1/0", sum, Cout, overflow);
    end
  endtask

  task automatic test_overflow();
    drive(MAXP, MAXP, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_pos got %h/%b/%b want fff..fe/0/1",
               sum, Cout, overflow);
    end
    drive(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001,
          1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_neg got %h/%b/%b want 2/1/1", sum, Cout, overflow);
    end
  endtask

  task automatic test_sub();
    drive(64'd37912, 64'd84021, 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {-64'd46109, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_small got %h/%b/%b want %h/0/0",
               sum, Cout, overflow, -64'd46109);
    end
    drive(-64'd53024, -64'd42502, 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {-64'd10522, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_neg got %h/%b/%b want %h/0/0",
               sum, Cout, overflow, -64'd10522);
    end
    drive(64'd5, -64'd5, 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_mixed got %h/%b/%b want a/0/0", sum, Cout, overflow);
    end
    drive(MAXP, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {ONES << 1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_ovf got %h/%b/%b want fff..fe/0/1",
               sum, Cout, overflow);
    end
    drive(64'd7, 64'd7, 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_equal got %h/%b/%b want 0/1/0", sum, Cout, overflow);
    end
  endtask

  task automatic test_logic();
    drive(LA, LB, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {LA & LB, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL and got %h/%b/%b want %h/0/0",
               sum, Cout, overflow, LA & LB);
    end
    drive(LA, LB, 1'b0, 1'b0, 1'b0, 2'b01);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {LA | LB, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL or got %h/%b/%b want %h/0/0",
               sum, Cout, overflow, LA | LB);
    end
    drive(LA, LB, 1'b0, 1'b0, 1'b0, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {LA ^ LB, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL xor got %h/%b/%b want %h/0/0",
               sum, Cout, overflow, LA ^ LB);
    end
    drive(LA, LB, 1'b0, 1'b0, 1'b0, 2'b10);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {LB, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL passb got %h/%b/%b want %h/0/0", sum, Cout, overflow, LB);
    end
    drive(64'd0, 64'h0F, 1'b1, 1'b0, 1'b0, 2'b10);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL passb_inv got %h/%b/%b want fff..f0/0/0",
               sum, Cout, overflow);
    end
    // Cin does not touch AND sum bits but still ripples through the carries
    drive(ONES, ONES, 1'b0, 1'b1, 1'b1, 2'b00);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {ONES, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL and_cin got %h/%b/%b want fff..f/1/0",
               sum, Cout, overflow);
    end
  endtask

  task automatic test_back_to_back();
    drive(64'd100, 64'd23, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd123, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_add got %h/%b/%b want 7b/0/0", sum, Cout, overflow);
    end
    drive(64'd100, 64'd23, 1'b1, 1'b1, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd77, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_sub got %h/%b/%b want 4d/1/0", sum, Cout, overflow);
    end
    drive(64'hF0F0, 64'hFF00, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'hF000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_and got %h/%b/%b want f000/0/0", sum, Cout, overflow);
    end
    drive(64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL nochain_cin got %h/%b/%b want 1/0/0",
               sum, Cout, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    drive(ONES, ONES, 1'b0, 1'b0, 1'b1, 2'b11);
    reset = 1'b1;
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset got %h/%b/%b want 0/0/0", sum, Cout, overflow);
    end
    reset = 1'b0;
    drive(64'd40, 64'd2, 1'b0, 1'b0, 1'b1, 2'b11);
    step();
    n_cmp++;
    if ({sum, Cout, overflow} !== {64'd42, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_release got %h/%b/%b want 2a/0/0",
               sum, Cout, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/adder.md
Name: adder

Overview:
- Registered ripple-carry bit-slice arithmetic/logic datapath of WIDTH identical 1-bit slices.
- Each slice computes AND, OR, pass-B or full-add of A, B and its carry-in.
- The B operand per bit goes through a 2:1 selector (submodule mux_2x1) choosing true or inverted B, so subtraction is B-invert with Cin=1.
- Sits in the CPU ALU; results are registered for one cycle.

Parameters:
- WIDTH, 64, number of bit slices (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- b_invert  input  1  1 = use ~B per bit (via mux_2x1), 0 = use B.
- Cin  input  1  carry into slice 0.
- Cout_sel  input  1  1 = carry chain enabled, 0 = every slice carry-out forced to 0.
- sum_sel  input  2  operation select: 00 AND, 01 OR, 10 pass B, 11 A^B^carry.
- sum  output  WIDTH  registered result.
- Cout  output  1  registered carry-out of MSB slice.
- overflow  output  1  registered carry[WIDTH-1] XOR carry[WIDTH-2].

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on a rising clk with reset=1, sum, Cout and overflow become 0. Reset wins over any other input.
- mux_2x1 submodule contract:
  - ports in[1:0], sel, out; combinational; out = in[sel].
  - One instance per bit, with in = {~B[i], B[i]} and sel = b_invert.
  - Result: Bi[i] = b_invert ? ~B[i] : B[i].
- Per-slice combinational function for bit i, where ci = Cin for i=0 and ci = c[i-1] otherwise:
  - c[i] = Cout_sel & ((A[i]&Bi[i]) | (A[i]&ci) | (Bi[i]&ci)).
  - s[i] by sum_sel:
    - 00 -> A[i]&Bi[i]
    - 01 -> A[i]|Bi[i]
    - 10 -> Bi[i]
    - 11 -> A[i]^Bi[i]^ci
- Carry chain is pure ripple from bit 0 to bit WIDTH-1. No lookahead is required; no combinational path goes through registers.
- Registered outputs, latency 1 cycle: on each rising clk with reset=0, sum<=s, Cout<=c[WIDTH-1], overflow<=c[WIDTH-1]^c[WIDTH-2]. Inputs are sampled every cycle with no handshake or valid signal; a new operation may be issued every cycle.
- Arithmetic is two's complement modulo 2^WIDTH.
  - Add: sum_sel=11, Cout_sel=1, b_invert=0, Cin=0.
  - Subtract A-B: sum_sel=11, Cout_sel=1, b_invert=1, Cin=1.
  - XOR: sum_sel=11, Cout_sel=0, Cin=0 (carries all 0, so s = A^Bi).
- Cout_sel=0 forces Cout=0 and overflow=0 regardless of Cin.
- Cin is ignored by AND/OR/pass-B for the sum bits, but still feeds the carry chain and thus Cout and overflow.
- Subtract equal operands: sum=0, Cout=1, overflow=0.
- Reset asserted mid-stream: the next edge clears outputs; the first post-reset result appears one cycle after reset deasserts.

Test Plan:
- Reset: reset=1 for 2 cycles with A=B=all ones, op=add -> sum=0, Cout=0, overflow=0. Deassert; one cycle later -> sum=all ones<<1 (-2), Cout=1, overflow=0.
- Addition:
  - 10000+10000 -> 20000, Cout=0, overflow=0.
  - (-53024)+(-42502) -> -95526, Cout=1, overflow=0.
  - 2+(-1) -> 1, Cout=1.
- Signed overflow:
  - 0x7FFF_FFFF_FFFF_FFFF + same -> 0xFFFF_FFFF_FFFF_FFFE, overflow=1, Cout=0.
  - (-0x7FFF_FFFF_FFFF_FFFF) + same -> 2, overflow=1, Cout=1.
- Subtraction:
  - 37912-84021 -> -46109, Cout=0.
  - (-53024)-(-42502) -> -10522.
  - 5-(-5) -> 10.
  - 0x7FFF_FFFF_FFFF_FFFF - (-0x7FFF_FFFF_FFFF_FFFF) -> -2, overflow=1.
  - 7-7 -> 0, Cout=1.
- Logic ops with A=759231314, B=371914018, Cout_sel=0, Cin=0, b_invert=0:
  - AND -> A&B; OR -> A|B; XOR -> A^B; pass-B -> B.
  - Cout=0 and overflow=0 in every case.
- Pipelining: issue add, sub and AND on three consecutive cycles -> each result appears exactly one cycle after its inputs, with no bubbles. Cout_sel=0 with Cin=1, sum_sel=11, A=B=0 -> sum=1, Cout=0.
